// File: rtl/idp_pkg.sv
// Shared codes for the integer-datapath sequencer: op classes, FSM states, mux selects.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package idp_pkg;

  typedef enum logic [2:0] {
    CLS_ALU_R  = 3'b000,
    CLS_ALU_I  = 3'b001,
    CLS_MULDIV = 3'b010,
    CLS_MFHI   = 3'b011,
    CLS_MFLO   = 3'b100,
    CLS_LDY    = 3'b101,
    CLS_LINK   = 3'b110,
    CLS_ILL    = 3'b111
  } op_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_READ = 2'b01,
    ST_EXEC = 2'b10,
    ST_WB   = 2'b11
  } state_e;

  // Y-mux sources
  localparam logic [2:0] YS_ALU = 3'b000;
  localparam logic [2:0] YS_HI  = 3'b001;
  localparam logic [2:0] YS_LO  = 3'b010;
  localparam logic [2:0] YS_DY  = 3'b011;
  localparam logic [2:0] YS_PC  = 3'b100;

  // Destination-address selects
  localparam logic [1:0] DA_RD  = 2'b00;
  localparam logic [1:0] DA_RT  = 2'b01;
  localparam logic [1:0] DA_R31 = 2'b10;
  localparam logic [1:0] DA_R29 = 2'b11;

  // Micro-op as captured on the handshake
  typedef struct packed {
    op_class_e  cls;
    logic [4:0] fs;
    logic [4:0] s;
    logic [4:0] t;
    logic [4:0] d;
  } uop_t;

endpackage

// File: rtl/idp_wb_decode.sv
// Write-back table: op class -> regfile write enable, Y-mux select, dest select, error.
// Latency: combinational.
// Backpressure: none; the caller qualifies the outputs with the WB state.
module idp_wb_decode
  import idp_pkg::*;
(
  input  op_class_e  cls,
  output logic       d_en,
  output logic [2:0] y_sel,
  output logic [1:0] da_sel,
  output logic       err
);

  // Per-class write-back settings; defaults cover ALU_R
  always_comb begin
    d_en   = 1'b1;
    y_sel  = YS_ALU;
    da_sel = DA_RD;
    err    = 1'b0;
    case (cls)
      CLS_ALU_R:  ;
      CLS_ALU_I:  da_sel = DA_RT;
      CLS_MULDIV: d_en = 1'b0;
      CLS_MFHI:   y_sel = YS_HI;
      CLS_MFLO:   y_sel = YS_LO;
      CLS_LDY: begin
        y_sel  = YS_DY;
        da_sel = DA_RT;
      end
      CLS_LINK: begin
        y_sel  = YS_PC;
        da_sel = DA_R31;
      end
      CLS_ILL: begin
        d_en = 1'b0;
        err  = 1'b1;
      end
      default: d_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/idp_sequencer.sv
// Multi-cycle controller sequencing one micro-op through READ, EXEC and WB on the integer datapath.
// Latency: accept to regfile write edge = 3 cycles (MULDIV: 2 + MULDIV_CYC); back-to-back throughput 3 cycles.
// Backpressure: op_ready only in IDLE and WB; op inputs are sampled solely on op_valid & op_ready.
module idp_sequencer
  import idp_pkg::*;
#(
  parameter int MULDIV_CYC = 1,  // EXEC dwell for MULDIV, 1..15
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_class,
  input  logic [4:0] op_fs,
  input  logic [4:0] op_s,
  input  logic [4:0] op_t,
  input  logic [4:0] op_d,
  input  logic       C,
  input  logic       V,
  input  logic       N,
  input  logic       Z,
  output logic [4:0] S_Addr,
  output logic [4:0] T_Addr,
  output logic [4:0] D_Addr,
  output logic [4:0] FS,
  output logic       T_Sel,
  output logic       HILO_LD,
  output logic       D_En,
  output logic [1:0] DA_sel,
  output logic [2:0] Y_Sel,
  output logic [3:0] flags_q,
  output logic       done,
  output logic       err,
  output logic       busy
);

  state_e           state, next_state;
  uop_t             op_q;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             last_exec;
  logic             wb_d_en, wb_err;
  logic [2:0]       wb_y_sel;
  logic [1:0]       wb_da_sel;

  assign last_exec = (cnt <= CNT_W'(1));

  // State register; reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and handshake decode
  always_comb begin
    next_state = state;
    accept     = op_valid & op_ready;
    case (state)
      ST_IDLE: if (accept) next_state = ST_READ;
      ST_READ: next_state = ST_EXEC;
      ST_EXEC: if (last_exec) next_state = ST_WB;
      ST_WB:   next_state = accept ? ST_READ : ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // op_ready is a registered copy of "next state accepts", so it is 0 while reset is applied
  always_ff @(posedge clk) begin
    if (!reset) op_ready <= 1'b0;
    else        op_ready <= (next_state == ST_IDLE) || (next_state == ST_WB);
  end

  // Capture the micro-op on the handshake; it then drives addresses and FS until the next accept
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q <= '0;
    end else if (accept) begin
      op_q.cls <= op_class_e'(op_class);
      op_q.fs  <= op_fs;
      op_q.s   <= op_s;
      op_q.t   <= op_t;
      op_q.d   <= op_d;
    end
  end

  // EXEC dwell counter: loaded during READ, counts down to 1 in EXEC
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (state == ST_READ) begin
      cnt <= (op_q.cls == CLS_MULDIV) ? CNT_W'(MULDIV_CYC) : CNT_W'(1);
    end else if (state == ST_EXEC && !last_exec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // ALU flags are captured only at the end of an ALU op's last EXEC cycle
  always_ff @(posedge clk) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (state == ST_EXEC && last_exec &&
                 (op_q.cls == CLS_ALU_R || op_q.cls == CLS_ALU_I)) begin
      flags_q <= {C, V, N, Z};
    end
  end

  idp_wb_decode u_wb_decode (
    .cls    (op_q.cls),
    .d_en   (wb_d_en),
    .y_sel  (wb_y_sel),
    .da_sel (wb_da_sel),
    .err    (wb_err)
  );

  assign S_Addr  = op_q.s;
  assign T_Addr  = op_q.t;
  assign D_Addr  = op_q.d;
  assign FS      = op_q.fs;
  assign T_Sel   = (state == ST_READ) && (op_q.cls == CLS_ALU_I);
  // HI/LO load at the end of MULDIV EXEC so a following MFHI/MFLO reads the new value
  assign HILO_LD = (state == ST_EXEC) && last_exec && (op_q.cls == CLS_MULDIV);
  assign done    = (state == ST_WB);
  assign D_En    = done & wb_d_en;
  assign err     = done & wb_err;
  assign Y_Sel   = done ? wb_y_sel  : YS_ALU;
  assign DA_sel  = done ? wb_da_sel : DA_RD;
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_idp_sequencer.sv
// Directed bench for idp_sequencer with MULDIV_CYC=4.
// Latency: drives inputs 1 ns after posedge and samples outputs there.
// Backpressure: ops are only presented when op_ready is expected high.
module tb_idp_sequencer;

  logic       clk;
  logic       reset;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_class;
  logic [4:0] op_fs, op_s, op_t, op_d;
  logic       C, V, N, Z;
  logic [4:0] S_Addr, T_Addr, D_Addr, FS;
  logic       T_Sel, HILO_LD, D_En;
  logic [1:0] DA_sel;
  logic [2:0] Y_Sel;
  logic [3:0] flags_q;
  logic       done, err, busy;

  int checks   = 0;
  int failures = 0;

  idp_sequencer #(.MULDIV_CYC(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_class(op_class),
    .op_fs(op_fs), .op_s(op_s), .op_t(op_t), .op_d(op_d),
    .C(C), .V(V), .N(N), .Z(Z),
    .S_Addr(S_Addr), .T_Addr(T_Addr), .D_Addr(D_Addr), .FS(FS),
    .T_Sel(T_Sel), .HILO_LD(HILO_LD), .D_En(D_En),
    .DA_sel(DA_sel), .Y_Sel(Y_Sel), .flags_q(flags_q),
    .done(done), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] cls, input logic [4:0] fs,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    op_valid = 1'b1;
    op_class = cls;
    op_fs    = fs;
    op_s     = s;
    op_t     = t;
    op_d     = d;
  endtask

  task automatic test_reset;
    reset = 1'b0; op_valid = 1'b0; op_class = 3'b000;
    op_fs = 5'd0; op_s = 5'd0; op_t = 5'd0; op_d = 5'd0;
    C = 1'b0; V = 1'b0; N = 1'b0; Z = 1'b0;
    tick; tick;
    checks++; if ({op_ready, busy, done, err, D_En, HILO_LD, T_Sel} !== 7'b0) begin failures++;
      $display("FAIL rst_ctrl got=%b exp=0000000", {op_ready, busy, done, err, D_En, HILO_LD, T_Sel}); end
    checks++; if ({S_Addr, T_Addr, D_Addr, FS} !== 20'h0) begin failures++;
      $display("FAIL rst_addr got=%h exp=00000", {S_Addr, T_Addr, D_Addr, FS}); end
    checks++; if ({DA_sel, Y_Sel, flags_q} !== 9'b0) begin failures++;
      $display("FAIL rst_sel got=%b exp=000000000", {DA_sel, Y_Sel, flags_q}); end
    reset = 1'b1;
    tick;
    checks++; if (op_ready !== 1'b1 || busy !== 1'b0) begin failures++;
      $display("FAIL rst_idle ready=%b busy=%b exp ready=1 busy=0", op_ready, busy); end
  endtask

  task automatic test_alu_r;
    present(3'b000, 5'd2, 5'd1, 5'd2, 5'd3);
    tick;  // READ
    op_valid = 1'b0;
    checks++; if (T_Sel !== 1'b0 || S_Addr !== 5'd1 || T_Addr !== 5'd2) begin failures++;
      $display("FAIL alu_r_read tsel=%b s=%0d t=%0d exp 0/1/2", T_Sel, S_Addr, T_Addr); end
    checks++; if (op_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin failures++;
      $display("FAIL alu_r_busy ready=%b busy=%b done=%b exp 0/1/0", op_ready, busy, done); end
    tick;  // EXEC
    checks++; if (FS !== 5'd2 || D_En !== 1'b0 || HILO_LD !== 1'b0) begin failures++;
      $display("FAIL alu_r_exec fs=%0d den=%b hilo=%b exp 2/0/0", FS, D_En, HILO_LD); end
    tick;  // WB
    checks++; if ({done, D_En, err} !== 3'b110 || Y_Sel !== 3'b000 || DA_sel !== 2'b00 || D_Addr !== 5'd3) begin failures++;
      $display("FAIL alu_r_wb done/den/err=%b ysel=%b da=%b d=%0d exp 110/000/00/3", {done, D_En, err}, Y_Sel, DA_sel, D_Addr); end
    checks++; if (op_ready !== 1'b1) begin failures++;
      $display("FAIL alu_r_wb_ready got=%b exp=1", op_ready); end
    tick;  // IDLE
    checks++; if (done !== 1'b0 || busy !== 1'b0 || D_En !== 1'b0) begin failures++;
      $display("FAIL alu_r_idle done=%b busy=%b den=%b exp 0/0/0", done, busy, D_En); end
  endtask

  task automatic test_back_to_back;
    present(3'b001, 5'd1, 5'd4, 5'd5, 5'd6);
    tick;  // READ
    op_valid = 1'b0;
    checks++; if (T_Sel !== 1'b1 || T_Addr !== 5'd5) begin failures++;
      $display("FAIL alu_i_tsel tsel=%b t=%0d exp 1/5", T_Sel, T_Addr); end
    tick;  // EXEC
    checks++; if (T_Sel !== 1'b0) begin failures++;
      $display("FAIL alu_i_tsel_exec got=%b exp=0", T_Sel); end
    tick;  // WB, second op presented here
    checks++; if (done !== 1'b1 || DA_sel !== 2'b01 || Y_Sel !== 3'b000 || D_En !== 1'b1) begin failures++;
      $display("FAIL alu_i_wb done=%b da=%b ysel=%b den=%b exp 1/01/000/1", done, DA_sel, Y_Sel, D_En); end
    present(3'b000, 5'd3, 5'd8, 5'd9, 5'd10);
    tick;  // READ of second op, no bubble
    op_valid = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0 || T_Sel !== 1'b0 || S_Addr !== 5'd8 || T_Addr !== 5'd9) begin failures++;
      $display("FAIL b2b_read busy=%b done=%b tsel=%b s=%0d t=%0d exp 1/0/0/8/9", busy, done, T_Sel, S_Addr, T_Addr); end
    tick; tick;  // EXEC, WB
    checks++; if (done !== 1'b1 || D_Addr !== 5'd10 || DA_sel !== 2'b00) begin failures++;
      $display("FAIL b2b_wb done=%b d=%0d da=%b exp 1/10/00", done, D_Addr, DA_sel); end
    tick;
  endtask

  task automatic test_muldiv_mfhi;
    int hilo_cnt;
    hilo_cnt = 0;
    present(3'b010, 5'd0, 5'd1, 5'd2, 5'd0);
    tick;  // READ
    op_valid = 1'b0;
    if (HILO_LD === 1'b1) hilo_cnt++;
    for (int i = 1; i <= 4; i++) begin
      tick;  // EXEC cycle i
      if (HILO_LD === 1'b1) hilo_cnt++;
      checks++; if (HILO_LD !== (i == 4) || done !== 1'b0) begin failures++;
        $display("FAIL muldiv_exec%0d hilo=%b done=%b exp %b/0", i, HILO_LD, done, (i == 4)); end
    end
    tick;  // WB
    if (HILO_LD === 1'b1) hilo_cnt++;
    checks++; if (done !== 1'b1 || D_En !== 1'b0 || err !== 1'b0) begin failures++;
      $display("FAIL muldiv_wb done=%b den=%b err=%b exp 1/0/0", done, D_En, err); end
    present(3'b011, 5'd0, 5'd0, 5'd0, 5'd7);
    for (int i = 0; i < 3; i++) begin
      tick;
      op_valid = 1'b0;
      if (HILO_LD === 1'b1) hilo_cnt++;
    end
    checks++; if (done !== 1'b1 || Y_Sel !== 3'b001 || D_Addr !== 5'd7 || D_En !== 1'b1 || DA_sel !== 2'b00) begin failures++;
      $display("FAIL mfhi_wb done=%b ysel=%b d=%0d den=%b da=%b exp 1/001/7/1/00", done, Y_Sel, D_Addr, D_En, DA_sel); end
    checks++; if (hilo_cnt !== 1) begin failures++;
      $display("FAIL hilo_count got=%0d exp=1", hilo_cnt); end
    tick;
  endtask

  task automatic test_link_illegal;
    present(3'b110, 5'd0, 5'd0, 5'd0, 5'd0);
    tick; op_valid = 1'b0; tick; tick;
    checks++; if (done !== 1'b1 || DA_sel !== 2'b10 || Y_Sel !== 3'b100 || D_En !== 1'b1 || err !== 1'b0) begin failures++;
      $display("FAIL link_wb done=%b da=%b ysel=%b den=%b err=%b exp 1/10/100/1/0", done, DA_sel, Y_Sel, D_En, err); end
    tick;
    present(3'b111, 5'd0, 5'd1, 5'd2, 5'd3);
    tick; op_valid = 1'b0; tick; tick;
    checks++; if (done !== 1'b1 || err !== 1'b1 || D_En !== 1'b0) begin failures++;
      $display("FAIL illegal_wb done=%b err=%b den=%b exp 1/1/0", done, err, D_En); end
    tick;
    checks++; if (err !== 1'b0 || done !== 1'b0) begin failures++;
      $display("FAIL illegal_pulse err=%b done=%b exp 0/0", err, done); end
  endtask

  task automatic test_flags;
    present(3'b000, 5'd2, 5'd1, 5'd2, 5'd3);
    tick;  // READ
    op_valid = 1'b0;
    tick;  // EXEC
    {C, V, N, Z} = 4'b1010;
    tick;  // WB
    checks++; if (flags_q !== 4'b1010) begin failures++;
      $display("FAIL flags_alu got=%b exp=1010", flags_q); end
    {C, V, N, Z} = 4'b0101;
    tick;
    present(3'b100, 5'd2, 5'd0, 5'd0, 5'd4);
    tick; op_valid = 1'b0; tick; tick;  // MFLO WB
    checks++; if (flags_q !== 4'b1010 || Y_Sel !== 3'b010) begin failures++;
      $display("FAIL flags_mflo flags=%b ysel=%b exp 1010/010", flags_q, Y_Sel); end
    {C, V, N, Z} = 4'b0000;
    tick;
  endtask

  task automatic test_reset_abort;
    int bad;
    bad = 0;
    present(3'b010, 5'd0, 5'd1, 5'd2, 5'd0);
    tick;  // READ
    op_valid = 1'b0;
    tick;  // EXEC cycle 1
    reset = 1'b0;
    tick;
    reset = 1'b1;
    checks++; if (busy !== 1'b0 || op_ready !== 1'b0 || HILO_LD !== 1'b0 || done !== 1'b0 || D_En !== 1'b0) begin failures++;
      $display("FAIL abort_state busy=%b ready=%b hilo=%b done=%b den=%b exp 00000", busy, op_ready, HILO_LD, done, D_En); end
    checks++; if (flags_q !== 4'b0000 || S_Addr !== 5'd0) begin failures++;
      $display("FAIL abort_regs flags=%b s=%0d exp 0000/0", flags_q, S_Addr); end
    for (int i = 0; i < 6; i++) begin
      tick;
      if (HILO_LD !== 1'b0 || D_En !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin failures++;
      $display("FAIL abort_quiet bad_cycles=%0d exp=0", bad); end
    checks++; if (op_ready !== 1'b1) begin failures++;
      $display("FAIL abort_ready got=%b exp=1", op_ready); end
  endtask

  initial begin
    test_reset;
    test_alu_r;
    test_back_to_back;
    test_muldiv_mfhi;
    test_link_illegal;
    test_flags;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
